// File: rtl/ram_loader_if.sv
// Handshake and RAM-port bundle between the byte source, the loader and the program RAM.
// master is the loader side; slave is the source/RAM/controller side.
interface ram_loader_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              start;
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_ready;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_wdata;
  logic [WIDTH-1:0]  ram_rdata;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    input  start, in_valid, in_data, ram_rdata,
    output in_ready, ram_we, ram_re, ram_addr, ram_wdata, busy, done, error
  );

  modport slave (
    output start, in_valid, in_data, ram_rdata,
    input  in_ready, ram_we, ram_re, ram_addr, ram_wdata, busy, done, error
  );
endinterface

// File: rtl/ram_loader.sv
// Streams DEPTH program bytes into RAM, reads them back and compares running checksums.
// busy holds the CPU off until the image has been verified.
module ram_loader #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input logic       clk,
  input logic       rst,
  ram_loader_if.master bus
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWrite = 3'd1;
  localparam logic [2:0] StDrain = 3'd2;
  localparam logic [2:0] StRead  = 3'd3;
  localparam logic [2:0] StCheck = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  wsum_q, wsum_d;
  logic [WIDTH-1:0]  rsum_q, rsum_d;
  logic              rd_pending_q, rd_pending_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_re_q, ram_re_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [WIDTH-1:0]  ram_wdata_q, ram_wdata_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              accept;

  assign accept = (state_q == StWrite) && bus.in_valid;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wsum_d       = wsum_q;
    // Read data returns one cycle after the strobe is sampled.
    rd_pending_d = ram_re_q;
    rsum_d       = rd_pending_q ? rsum_q + bus.ram_rdata : rsum_q;
    ram_we_d     = 1'b0;
    ram_re_d     = ram_re_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    done_d       = done_q;
    error_d      = error_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StWrite;
          addr_d  = '0;
          wsum_d  = '0;
          rsum_d  = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      StWrite: begin
        if (accept) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = addr_q;
          ram_wdata_d = bus.in_data;
          wsum_d      = wsum_q + bus.in_data;
          addr_d      = addr_q + ADDR_W'(1);
          if (addr_q == LastAddr) state_d = StDrain;
        end
      end
      StDrain: begin
        ram_re_d   = 1'b1;
        ram_addr_d = '0;
        state_d    = StRead;
      end
      StRead: begin
        if (ram_addr_q == LastAddr) begin
          ram_re_d = 1'b0;
          state_d  = StCheck;
        end else begin
          ram_addr_d = ram_addr_q + ADDR_W'(1);
        end
      end
      StCheck: begin
        if (!rd_pending_q) begin
          error_d = (rsum_q != wsum_q);
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wsum_q       <= '0;
      rsum_q       <= '0;
      rd_pending_q <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_re_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wsum_q       <= wsum_d;
      rsum_q       <= rsum_d;
      rd_pending_q <= rd_pending_d;
      ram_we_q     <= ram_we_d;
      ram_re_q     <= ram_re_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.in_ready  = (state_q == StWrite);
  assign bus.busy      = (state_q == StWrite) || (state_q == StDrain) ||
                         (state_q == StRead)  || (state_q == StCheck);
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_re    = ram_re_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: RAM model, write scoreboard queue, readback
// address tracking and done latency, across several program-load scenarios.
module tb_ram_loader;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_loader_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  ram_loader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int corrupt_addr = -1;
  logic [7:0] mem [16];

  // Program RAM model; optionally flips bit0 of one address on readback.
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_re)
      bus.ram_rdata <= mem[bus.ram_addr] ^
                       ((int'(bus.ram_addr) == corrupt_addr) ? 8'h01 : 8'h00);
  end

  task automatic run_session(input logic [7:0] d [16], input int gaps, input int corrupt,
                             input bit poke_start, input bit exp_err, input string name);
    logic [11:0] wq [$];
    logic [11:0] exp_w;
    logic [3:0]  prev_a;
    logic [3:0]  exp_a;
    logic        prev_re;
    logic        exp_we;
    bit          last_sent;
    bit          got_done;
    int          sent, gap_left, lat, done_lat, wec, rec, run, maxrun;
    sent = 0; gap_left = 0; lat = -1; done_lat = -1; wec = 0; rec = 0; run = 0; maxrun = 0;
    prev_a = '0; prev_re = 1'b0; exp_we = 1'b0; last_sent = 1'b0; got_done = 1'b0;
    corrupt_addr = corrupt;

    @(negedge clk);
    bus.start = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (last_sent) lat++;
      if (cyc == 0) begin
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.error !== 1'b0) begin
          errors++;
          $display("FAIL %s start_state: busy/done/error=%b%b%b required 100", name,
                   bus.busy, bus.done, bus.error);
        end
      end
      checks++;
      if (bus.ram_we !== exp_we) begin
        errors++;
        $display("FAIL %s we_timing: ram_we=%b required %b", name, bus.ram_we, exp_we);
      end
      if (bus.ram_we === 1'b1) begin
        wec++;
        checks++;
        if (bus.ram_re === 1'b1) begin
          errors++;
          $display("FAIL %s we_re_overlap: both strobes high, required exclusive", name);
        end
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL %s write_unexpected: addr=%h data=%h required none", name,
                   bus.ram_addr, bus.ram_wdata);
        end else begin
          exp_w = wq.pop_front();
          if ({bus.ram_addr, bus.ram_wdata} !== exp_w) begin
            errors++;
            $display("FAIL %s write: addr/data=%h required %h", name,
                     {bus.ram_addr, bus.ram_wdata}, exp_w);
          end
        end
      end
      if (bus.ram_re === 1'b1) begin
        rec++;
        run++;
        if (run > maxrun) maxrun = run;
        exp_a = prev_re ? prev_a + 4'd1 : 4'd0;
        checks++;
        if (bus.ram_addr !== exp_a) begin
          errors++;
          $display("FAIL %s read_addr: addr=%h required %h", name, bus.ram_addr, exp_a);
        end
        prev_a = bus.ram_addr;
      end else begin
        run = 0;
      end
      prev_re = bus.ram_re;
      if (last_sent && lat == 0) begin
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL %s drain: in_ready/busy=%b%b required 01", name,
                   bus.in_ready, bus.busy);
        end
      end
      if (bus.done === 1'b1) begin
        got_done = 1'b1;
        done_lat = lat;
        break;
      end
      bus.start = (poke_start && lat == 4) ? 1'b1 : 1'b0;
      exp_we = 1'b0;
      if (sent < 16 && gap_left == 0) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin
          errors++;
          $display("FAIL %s in_ready: got %b required 1", name, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d[sent];
        wq.push_back({4'(sent), d[sent]});
        exp_we = 1'b1;
        sent++;
        gap_left = gaps;
        if (sent == 16) last_sent = 1'b1;
      end else begin
        if (gap_left > 0) gap_left--;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
      end
    end
    bus.start = 1'b0;
    bus.in_valid = 1'b0;

    checks++;
    if (!got_done || done_lat != 19) begin
      errors++;
      $display("FAIL %s done_latency: got %0d required 19", name, done_lat);
    end
    checks++;
    if (bus.error !== exp_err) begin
      errors++;
      $display("FAIL %s error: got %b required %b", name, bus.error, exp_err);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b required 0", name, bus.busy);
    end
    checks++;
    if (wec != 16 || rec != 16 || maxrun != 16 || wq.size() != 0) begin
      errors++;
      $display("FAIL %s strobe_counts: we=%0d re=%0d run=%0d left=%0d required 16 16 16 0",
               name, wec, rec, maxrun, wq.size());
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== d[i]) begin
        errors++;
        $display("FAIL %s ram[%0d]: got %h required %h", name, i, mem[i], d[i]);
      end
    end
    corrupt_addr = -1;
    // done must stay high as a level while idle in DONE.
    repeat (3) @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.error !== exp_err) begin
      errors++;
      $display("FAIL %s done_hold: done/error=%b%b required 1%b", name, bus.done, bus.error,
               exp_err);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.start    = 1'($urandom);
      bus.in_valid = 1'($urandom);
      bus.in_data  = 8'($urandom);
      #1;
      checks++;
      if ({bus.in_ready, bus.ram_we, bus.ram_re, bus.busy, bus.done, bus.error} !== 6'b0) begin
        errors++;
        $display("FAIL reset_outputs: rdy/we/re/busy/done/err=%b required 000000",
                 {bus.in_ready, bus.ram_we, bus.ram_re, bus.busy, bus.done, bus.error});
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_data = 8'($urandom);
      checks++;
      if ({bus.in_ready, bus.ram_we, bus.ram_re, bus.busy, bus.done} !== 5'b0) begin
        errors++;
        $display("FAIL idle_no_start: rdy/we/re/busy/done=%b required 00000",
                 {bus.in_ready, bus.ram_we, bus.ram_re, bus.busy, bus.done});
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_nominal();
    logic [7:0] d [16];
    for (int i = 0; i < 16; i++) d[i] = 8'(i);
    run_session(d, 0, -1, 1'b0, 1'b0, "nominal");
  endtask

  task automatic test_gapped();
    logic [7:0] d [16];
    for (int i = 0; i < 16; i++) d[i] = 8'hA0 + 8'(i);
    run_session(d, 2, -1, 1'b0, 1'b0, "gapped");
  endtask

  task automatic test_checksum_wrap();
    logic [7:0] d [16];
    for (int i = 0; i < 16; i++) d[i] = 8'hFF;
    run_session(d, 0, -1, 1'b0, 1'b0, "wrap");
  endtask

  task automatic test_corruption();
    logic [7:0] d [16];
    for (int i = 0; i < 16; i++) d[i] = 8'h30 + 8'(i * 3);
    run_session(d, 0, 5, 1'b0, 1'b1, "corrupt");
  endtask

  task automatic test_mid_session();
    logic [7:0] d [16];
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h50 + 8'(i);
      if (i < 6) @(negedge clk);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.ram_we !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: we/busy/rdy=%b%b%b required 000", bus.ram_we, bus.busy,
               bus.in_ready);
    end
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) d[i] = 8'hC3 ^ 8'(i * 7);
    run_session(d, 0, -1, 1'b1, 1'b0, "restart");
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    test_reset();
    test_nominal();
    test_gapped();
    test_checksum_wrap();
    test_corruption();
    test_mid_session();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
